// File: rtl/seq_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen_if
// Brief    : Control/stream bundle for the serial pattern transmitter.
// Revision : 1.0
// ============================================================================
interface seq_pattern_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] rep_count;
    logic             abort;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_count;

    modport master (
        output start, pattern, rep_count, abort,
        input  out_bit, out_valid, busy, done, sent_count
    );

    modport slave (
        input  start, pattern, rep_count, abort,
        output out_bit, out_valid, busy, done, sent_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Sends a latched PAT_W-bit pattern MSB first, rep_count times,
//            with GAP_BITS zero bits between repetitions.
// Revision : 1.0
// ============================================================================
module seq_pattern_gen #(
    parameter int PAT_W    = 4,
    parameter int CNT_W    = 8,
    parameter int GAP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_pattern_gen_if.slave     bus
);
    localparam int BIT_CW = $clog2(PAT_W + 1);
    localparam int GAP_CW = (GAP_BITS < 2) ? 1 : $clog2(GAP_BITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [BIT_CW-1:0] C_PAT    = BIT_CW'(PAT_W);
    localparam logic [BIT_CW-1:0] C_B_ONE  = BIT_CW'(1);
    localparam logic [GAP_CW-1:0] C_GAP    = GAP_CW'(GAP_BITS);
    localparam logic [GAP_CW-1:0] C_G_ONE  = GAP_CW'(1);

    logic [1:0]        state_q,     state_d;
    logic [PAT_W-1:0]  shreg_q,     shreg_d;
    logic [PAT_W-1:0]  pat_q,       pat_d;
    logic [CNT_W-1:0]  rep_q,       rep_d;
    logic [BIT_CW-1:0] bitcnt_q,    bitcnt_d;
    logic [GAP_CW-1:0] gapcnt_q,    gapcnt_d;
    logic              out_bit_q,   out_bit_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [CNT_W-1:0]  sent_q,      sent_d;

    logic [CNT_W:0]    w_sent_inc;
    logic              w_more;
    logic [CNT_W-1:0]  w_sent_sat;

    // w_more: another repetition follows the pattern that is finishing now.
    assign w_sent_inc = {1'b0, sent_q} + (CNT_W+1)'(1);
    assign w_more     = w_sent_inc < {1'b0, rep_q};
    assign w_sent_sat = (&sent_q) ? sent_q : w_sent_inc[CNT_W-1:0];

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        pat_d       = pat_q;
        rep_d       = rep_q;
        bitcnt_d    = bitcnt_q;
        gapcnt_d    = gapcnt_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        sent_d      = sent_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    sent_d = '0;
                    if (bus.rep_count != '0) begin
                        pat_d       = bus.pattern;
                        rep_d       = bus.rep_count;
                        state_d     = S_SEND;
                        out_bit_d   = bus.pattern[PAT_W-1];
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        shreg_d     = bus.pattern << 1;
                        bitcnt_d    = C_B_ONE;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bitcnt_q == C_PAT) begin
                    sent_d = w_sent_sat;
                    if (!w_more) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (GAP_BITS > 0) begin
                        state_d     = S_GAP;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        gapcnt_d    = C_G_ONE;
                    end else begin
                        out_bit_d   = pat_q[PAT_W-1];
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        shreg_d     = pat_q << 1;
                        bitcnt_d    = C_B_ONE;
                    end
                end else begin
                    out_bit_d   = shreg_q[PAT_W-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    shreg_d     = shreg_q << 1;
                    bitcnt_d    = bitcnt_q + C_B_ONE;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (gapcnt_q == C_GAP) begin
                    state_d     = S_SEND;
                    out_bit_d   = pat_q[PAT_W-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    shreg_d     = pat_q << 1;
                    bitcnt_d    = C_B_ONE;
                end else begin
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    gapcnt_d    = gapcnt_q + C_G_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            pat_q       <= '0;
            rep_q       <= '0;
            bitcnt_q    <= '0;
            gapcnt_q    <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            pat_q       <= pat_d;
            rep_q       <= rep_d;
            bitcnt_q    <= bitcnt_d;
            gapcnt_q    <= gapcnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sent_q      <= sent_d;
        end
    end

    assign bus.out_bit    = out_bit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sent_count = sent_q;
endmodule
`default_nettype wire
